vend_controller: RTL and testbench
==================================

# vend_controller

Transaction sequencer for the coin-operated vending path. It accumulates coin credit and compares it against a fixed product price. On a buy request it drives the product dispenser through a req/ack handshake, then pays out change one 5-unit coin at a time through the change hopper's req/ack handshake. It sits between the coin acceptor (one-cycle coin pulses) and the dispenser/hopper actuators, and also serves cancel/refund.

## Interface
- `PRICE`, 15: product price in currency units; multiple of 5, at least 5, at most MAX_CREDIT.
- `MAX_CREDIT`, 30: highest credit accepted; multiple of 5, at most 63.
- `TIMEOUT`, 255: idle cycles before auto-refund (see Configuration); at least 1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `coin_valid` in 1: one-cycle pulse, coin present.
- `coin_val` in 2: 2'b01 = 5, 2'b10 = 10; 2'b00/2'b11 invalid.
- `sel` in 1: buy request, sampled each cycle.
- `cancel` in 1: refund request, sampled each cycle.
- `disp_ack` in 1: dispenser done.
- `chg_ack` in 1: hopper has ejected one 5-unit coin.
- `disp_req` out 1: dispense request, level.
- `chg_req` out 1: change request, level.
- `coin_reject` out 1: one-cycle pulse, the coin is returned physically.
- `credit` out 6: current credit.
- `busy` out 1: high in the DISPENSE and CHANGE states.

## Operation
- States are IDLE, CREDIT, DISPENSE and CHANGE. All outputs are registered.
- Reset values: state IDLE, credit 0, and disp_req, chg_req, coin_reject, busy all 0.
- Coin handling:
  - A coin is accepted only in IDLE or CREDIT.
  - It must be a valid code, and credit+value must not exceed MAX_CREDIT.
  - When accepted, credit += value. IDLE goes to CREDIT.
  - Any other coin_valid pulse (invalid code, overflow, busy state) gives coin_reject = 1 for one cycle with credit unchanged.
- CREDIT state transitions:
  - cancel goes to CHANGE (refund of the full credit).
  - Otherwise, sel with credit >= PRICE goes to DISPENSE.
  - sel with credit < PRICE is ignored.
  - cancel has priority over sel.
- Coin and sel/cancel in the same cycle:
  - The coin is accepted and added to credit.
  - The sel decision uses the credit from before the coin.
  - The added coin is included in any later change or refund.
- DISPENSE:
  - disp_req is high while in this state.
  - When disp_ack is sampled high: credit -= PRICE and disp_req goes low.
  - Next state is CHANGE if the new credit > 0, otherwise IDLE.
  - cancel and sel are ignored here.
- CHANGE:
  - chg_req is high while credit > 0.
  - Each cycle with chg_ack high does credit -= 5. Back-to-back acks are legal, one coin per cycle.
  - When credit reaches 0: chg_req low and state IDLE.
- Acks sampled while the matching req is low are ignored.
- Arithmetic is unsigned, 6 bits. Credit never underflows, because PRICE <= credit on entry to DISPENSE and credit is always a multiple of 5.
- Reset mid-transaction aborts immediately. Credit is lost, no refund, and req lines drop asynchronously.

## Timing
- Accepted coin: credit updates on the edge that samples coin_valid and is visible the next cycle.
- coin_reject is asserted the cycle after the offending coin_valid.
- Dispense latency: disp_req rises 1 cycle after the sel that qualifies.
- disp_req falls the cycle after disp_ack is sampled. chg_req rises in that same cycle if change is owed.
- chg_req falls in the cycle after the final chg_ack.
- A refund of N units takes N/5 acks.
- busy equals (state==DISPENSE or state==CHANGE) and follows the state with no added delay.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - An idle counter runs in CREDIT. It is cleared by any coin_valid, sel or cancel.
  - When it reaches TIMEOUT cycles, the block moves to CHANGE and refunds the full credit, exactly like cancel.
- Not defined: the counter is absent and CREDIT holds indefinitely.

## Test plan
- Reset, coin 10, coin 5, sel:
  - disp_req rises the cycle after sel; ack it.
  - credit reads 0, state returns to IDLE, chg_req is never asserted.
- Coin 10, coin 10, sel:
  - After disp_ack, credit = 5 and chg_req is high.
  - One chg_ack gives credit 0 and chg_req low the next cycle.
- Coins 10, 10, 10 (credit 30), then a further coin 5: coin_reject pulses once and credit stays 30.
- Coin 10 and cancel in the same cycle as a second coin 5: credit reaches 15, then three chg_acks refund it to 0.
- Coin during DISPENSE gives coin_reject. Separately:
  - Invalid code 2'b11 in IDLE gives coin_reject with credit 0.
  - sel with credit 5 is ignored.
- With VEND_TIMEOUT_EN and TIMEOUT=4: coin 5, then idle → chg_req on the 5th cycle. Without the macro, no change request ever.

Source files
------------

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, dispense handshake, 5-unit change/refund payout.
// Optional VEND_TIMEOUT_EN: auto-refund after TIMEOUT idle cycles in CREDIT.
module vend_controller #(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 30,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  input  logic       sel,
  input  logic       cancel,
  input  logic       disp_ack,
  input  logic       chg_ack,
  output logic       disp_req,
  output logic       chg_req,
  output logic       coin_reject,
  output logic [5:0] credit,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  state_t     state, state_next;
  logic [5:0] credit_next;
  logic       disp_req_next, chg_req_next, coin_reject_next, busy_next;

  logic [5:0] coin_amt;
  logic       coin_code_ok;
  logic [6:0] coin_sum;
  logic       coin_accept;
  logic [5:0] credit_coin;
  logic       timeout_hit;

  if (TIMEOUT < 1 || PRICE < 5 || PRICE > MAX_CREDIT || MAX_CREDIT > 63) begin : g_bad_params
    $error("vend_controller: illegal parameter combination");
  end

  always_comb begin
    coin_amt     = 6'd0;
    coin_code_ok = 1'b0;
    case (coin_val)
      2'b01: begin coin_amt = 6'd5;  coin_code_ok = 1'b1; end
      2'b10: begin coin_amt = 6'd10; coin_code_ok = 1'b1; end
      default: ;
    endcase
  end

  // Sum is one bit wider so an overflowing coin cannot wrap past the limit check.
  assign coin_sum    = {1'b0, credit} + {1'b0, coin_amt};
  assign coin_accept = coin_valid && coin_code_ok &&
                       (state == IDLE || state == CREDIT) &&
                       (coin_sum <= 7'(MAX_CREDIT));
  assign credit_coin = coin_accept ? coin_sum[5:0] : credit;

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          activity;

  assign activity    = coin_valid || sel || cancel;
  assign timeout_hit = (state == CREDIT) && !activity && (idle_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (state != CREDIT || activity) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TW'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      credit <= 6'd0;
    end else begin
      state  <= state_next;
      credit <= credit_next;
    end
  end

  always_comb begin
    state_next  = state;
    credit_next = credit_coin;
    case (state)
      IDLE: begin
        if (coin_accept) state_next = CREDIT;
      end
      CREDIT: begin
        // sel is judged on the pre-coin credit; a same-cycle coin still lands in credit_next.
        if (cancel || timeout_hit)
          state_next = CHANGE;
        else if (sel && credit >= 6'(PRICE))
          state_next = DISPENSE;
      end
      DISPENSE: begin
        if (disp_ack) begin
          credit_next = credit - 6'(PRICE);
          state_next  = (credit_next != 6'd0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        if (credit == 6'd0) begin
          state_next = IDLE;
        end else if (chg_ack) begin
          credit_next = credit - 6'd5;
          if (credit_next == 6'd0) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    disp_req_next    = (state_next == DISPENSE);
    chg_req_next     = (state_next == CHANGE) && (credit_next != 6'd0);
    busy_next        = (state_next == DISPENSE) || (state_next == CHANGE);
    coin_reject_next = coin_valid && !coin_accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_req    <= 1'b0;
      chg_req     <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      disp_req    <= disp_req_next;
      chg_req     <= chg_req_next;
      coin_reject <= coin_reject_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus queues expected output snapshots, a monitor
// compares them against every observed output change, including the cycle it occurs in.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_val = 2'b00;
  logic       sel = 1'b0, cancel = 1'b0, disp_ack = 1'b0, chg_ack = 1'b0;
  logic       disp_req, chg_req, coin_reject, busy;
  logic [5:0] credit;

  vend_controller #(.PRICE(15), .MAX_CREDIT(30), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel(sel), .cancel(cancel), .disp_ack(disp_ack), .chg_ack(chg_ack),
    .disp_req(disp_req), .chg_req(chg_req), .coin_reject(coin_reject),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;
  logic [9:0] vec;

  assign vec = {disp_req, chg_req, coin_reject, busy, credit};

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector {disp_req,chg_req,coin_reject,busy,credit} after the next edge.
  task automatic expect_out(input logic d, input logic c, input logic r, input logic b, input int cr);
    exp_t e;
    e.cyc = cyc + 1;
    e.v   = {d, c, r, b, 6'(cr)};
    q.push_back(e);
  endtask

  task automatic step(input logic cv, input logic [1:0] val, input logic s, input logic cn,
                      input logic da, input logic ca);
    coin_valid = cv;
    coin_val   = val;
    sel        = s;
    cancel     = cn;
    disp_ack   = da;
    chg_ack    = ca;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [9:0] prev;
    logic [9:0] cur;
    exp_t       e;
    wait (rst == 1'b1);
    prev = '0;
    forever begin
      @(negedge clk);
      cur = vec;
      if (mon_en && cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
        end else begin
          e = q.pop_front();
          if (cur !== e.v || cyc != e.cyc) begin
            errors++;
            $display("FAIL output_event got=%b at cyc %0d required=%b at cyc %0d",
                     cur, cyc, e.v, e.cyc);
          end else begin
            $display("ok   cyc=%0d d=%b c=%b rej=%b busy=%b credit=%0d",
                     cyc, cur[9], cur[8], cur[7], cur[6], cur[5:0]);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vec !== 10'd0) begin
      errors++;
      $display("FAIL reset_state got=%b required=%b", vec, 10'd0);
    end
    rst = 1'b1;

    // Exact price: 10 + 5, sel, coin during dispense rejected, ack.
    expect_out(0, 0, 0, 0, 10); step(1, 2'b10, 0, 0, 0, 0);
    expect_out(0, 0, 0, 0, 15); step(1, 2'b01, 0, 0, 0, 0);
    expect_out(1, 0, 0, 1, 15); step(0, 2'b00, 1, 0, 0, 0);
    expect_out(1, 0, 1, 1, 15); step(1, 2'b01, 0, 0, 0, 0);
    expect_out(1, 0, 0, 1, 15); step(0, 2'b00, 0, 1, 0, 1);
    expect_out(0, 0, 0, 0, 0);  step(0, 2'b00, 0, 0, 1, 0);
    idle(2);

    // Acks while idle are ignored; 10 + 10 gives 5 change.
    step(0, 2'b00, 0, 0, 1, 1);
    expect_out(0, 0, 0, 0, 10); step(1, 2'b10, 0, 0, 0, 0);
    expect_out(0, 0, 0, 0, 20); step(1, 2'b10, 0, 0, 0, 0);
    expect_out(1, 0, 0, 1, 20); step(0, 2'b00, 1, 0, 0, 0);
    idle(1);
    expect_out(0, 1, 0, 1, 5);  step(0, 2'b00, 0, 0, 1, 0);
    idle(1);
    expect_out(0, 0, 0, 0, 0);  step(0, 2'b00, 0, 0, 0, 1);
    idle(1);

    // Fill to MAX_CREDIT, overflow coin rejected, cancel refunds 30 with back-to-back acks.
    expect_out(0, 0, 0, 0, 10); step(1, 2'b10, 0, 0, 0, 0);
    expect_out(0, 0, 0, 0, 20); step(1, 2'b10, 0, 0, 0, 0);
    expect_out(0, 0, 0, 0, 30); step(1, 2'b10, 0, 0, 0, 0);
    expect_out(0, 0, 1, 0, 30); step(1, 2'b01, 0, 0, 0, 0);
    expect_out(0, 0, 0, 0, 30); idle(1);
    expect_out(0, 1, 0, 1, 30); step(0, 2'b00, 0, 1, 0, 0);
    for (int v = 25; v > 0; v -= 5) begin
      expect_out(0, 1, 0, 1, v); step(0, 2'b00, 1, 1, 0, 1);
    end
    expect_out(0, 0, 0, 0, 0);  step(0, 2'b00, 0, 0, 0, 1);
    idle(1);

    // Coin with simultaneous cancel is included in the refund.
    expect_out(0, 0, 0, 0, 10); step(1, 2'b10, 0, 0, 0, 0);
    expect_out(0, 1, 0, 1, 15); step(1, 2'b01, 0, 1, 0, 0);
    expect_out(0, 1, 0, 1, 10); step(0, 2'b00, 0, 0, 0, 1);
    idle(1);
    expect_out(0, 1, 0, 1, 5);  step(0, 2'b00, 0, 0, 0, 1);
    expect_out(0, 0, 0, 0, 0);  step(0, 2'b00, 0, 0, 0, 1);
    idle(1);

    // Invalid codes rejected; sel with credit 5 ignored.
    expect_out(0, 0, 1, 0, 0);  step(1, 2'b11, 0, 0, 0, 0);
    expect_out(0, 0, 0, 0, 0);  idle(1);
    expect_out(0, 0, 0, 0, 5);  step(1, 2'b01, 0, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0, 0);
    idle(1);
    expect_out(0, 0, 1, 0, 5);  step(1, 2'b00, 0, 0, 0, 0);
    expect_out(0, 0, 0, 0, 5);  idle(1);

    // sel uses pre-coin credit: 5+10 with sel stays, 15+5 with sel dispenses 20.
    expect_out(0, 0, 0, 0, 15); step(1, 2'b10, 1, 0, 0, 0);
    expect_out(1, 0, 0, 1, 20); step(1, 2'b01, 1, 0, 0, 0);
    expect_out(0, 1, 0, 1, 5);  step(0, 2'b00, 0, 0, 1, 0);
    expect_out(0, 0, 0, 0, 0);  step(0, 2'b00, 0, 0, 0, 1);
    idle(1);

    // Idle credit: auto-refund when enabled, otherwise holds until cancel.
    expect_out(0, 0, 0, 0, 5);  step(1, 2'b01, 0, 0, 0, 0);
`ifdef VEND_TIMEOUT_EN
    idle(4);
    expect_out(0, 1, 0, 1, 5);  idle(1);
`else
    idle(20);
    expect_out(0, 1, 0, 1, 5);  step(0, 2'b00, 0, 1, 0, 0);
`endif
    expect_out(0, 0, 0, 0, 0);  step(0, 2'b00, 0, 0, 0, 1);
    idle(3);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d outstanding required=0", q.size());
    end
    mon_en = 1'b0;

    // Reset mid-dispense drops everything without waiting for a clock edge.
    step(1, 2'b10, 0, 0, 0, 0);
    step(1, 2'b10, 0, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0, 0);
    checks++;
    if (vec !== {1'b1, 1'b0, 1'b0, 1'b1, 6'd20}) begin
      errors++;
      $display("FAIL pre_reset_dispense got=%b required=%b", vec, {1'b1, 1'b0, 1'b0, 1'b1, 6'd20});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (vec !== 10'd0) begin
      errors++;
      $display("FAIL async_reset got=%b required=%b", vec, 10'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
